// File: rtl/param_datapath.sv
// Parametrised Mini SRC datapath: encoded bus mux, iterative signed MUL/DIV, req/ack memory port.
// Define DP_MEM_TIMEOUT_EN to abort a memory request after 15 cycles without ack (sticky o_mem_err).
module param_datapath #(
  parameter int  DATA_W   = 32,
  parameter int  NUM_REGS = 16,
  parameter int  IMM_W    = 19,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [2:0]        i_src_kind,
  input  logic [RW-1:0]     i_src_reg,
  input  logic              i_ba_out,
  input  logic              i_reg_we,
  input  logic [RW-1:0]     i_dst_reg,
  input  logic              i_pc_in,
  input  logic              i_ir_in,
  input  logic              i_y_in,
  input  logic              i_mar_in,
  input  logic              i_mdr_in,
  input  logic              i_hi_in,
  input  logic              i_lo_in,
  input  logic              i_out_in,
  input  logic              i_inc_pc,
  input  logic              i_c_out,
  input  logic [3:0]        i_alu_op,
  input  logic              i_z_in,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_in_port,
  input  logic              i_strobe,
  output logic [DATA_W-1:0] o_out_port,
  output logic [DATA_W-1:0] o_ir_value,
  output logic              o_busy,
  output logic              o_mem_err
);
  localparam int SW = $clog2(DATA_W);

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;
  typedef enum logic {MEM_IDLE, MEM_REQ} mem_state_t;

  md_state_t   r_md_state, w_md_next;
  mem_state_t  r_mem_state, w_mem_next;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_pc, r_ir, r_y, r_hi, r_lo, r_zhi, r_zlo;
  logic [DATA_W-1:0] r_mar, r_mdr, r_in, r_out;
  logic              r_mem_we;

  logic [DATA_W-1:0] r_md_a, r_md_b, r_md_hi, r_md_lo;
  logic [SW-1:0]     r_md_cnt;
  logic              r_md_is_div, r_md_neg_q, r_md_neg_r;

  logic [DATA_W-1:0]   w_bus, w_a, w_b, w_imm, w_alu, w_abs_a, w_abs_b;
  logic [DATA_W-1:0]   w_div_diff, w_quot, w_rem;
  logic [DATA_W:0]     w_mul_sum, w_div_sh;
  logic [2*DATA_W-1:0] w_prod_mag, w_prod;
  logic [3:0]          w_op;
  logic [SW-1:0]       w_sh, w_rot;
  logic                w_is_md_op, w_md_start, w_alu_z, w_div_ge;
  logic                w_mem_start, w_mem_rd_done, w_timeout;

  always_comb begin
    w_bus = '0;
    case (i_src_kind)
      3'd0: w_bus = (i_ba_out && i_src_reg == '0) ? '0 : r_regs[i_src_reg];
      3'd1: w_bus = r_pc;
      3'd2: w_bus = r_zlo;
      3'd3: w_bus = r_zhi;
      3'd4: w_bus = r_hi;
      3'd5: w_bus = r_lo;
      3'd6: w_bus = r_mdr;
      3'd7: w_bus = r_in;
    endcase
  end

  assign w_imm = DATA_W'($signed(r_ir[IMM_W-1:0]));
  assign w_a   = i_inc_pc ? DATA_W'(1) : r_y;
  assign w_b   = i_c_out ? w_imm : w_bus;
  assign w_op  = i_inc_pc ? 4'd0 : i_alu_op;
  assign w_sh  = w_b[SW-1:0];
  assign w_rot = SW'(int'(w_sh) % DATA_W);

  always_comb begin
    w_alu = '0;
    case (w_op)
      4'd0:  w_alu = w_a + w_b;
      4'd1:  w_alu = w_a - w_b;
      4'd2:  w_alu = w_a & w_b;
      4'd3:  w_alu = w_a | w_b;
      4'd4:  w_alu = w_a >> w_sh;
      4'd5:  w_alu = $signed(w_a) >>> w_sh;
      4'd6:  w_alu = w_a << w_sh;
      4'd7:  w_alu = (w_a >> w_rot) | (w_a << (DATA_W - int'(w_rot)));
      4'd8:  w_alu = (w_a << w_rot) | (w_a >> (DATA_W - int'(w_rot)));
      4'd9:  w_alu = -w_b;
      4'd10: w_alu = ~w_b;
      default: w_alu = '0;
    endcase
  end

  // MUL/DIV run on magnitudes; signs are reapplied when the result is written to Z.
  assign w_is_md_op = (w_op == 4'd11) || (w_op == 4'd12);
  assign w_md_start = i_z_in && (r_md_state == MD_IDLE) && w_is_md_op;
  assign w_alu_z    = i_z_in && (r_md_state == MD_IDLE) && !w_is_md_op;
  assign w_abs_a    = w_a[DATA_W-1] ? -w_a : w_a;
  assign w_abs_b    = w_b[DATA_W-1] ? -w_b : w_b;

  assign w_mul_sum  = {1'b0, r_md_hi} + {1'b0, (r_md_lo[0] ? r_md_b : '0)};
  assign w_div_sh   = {r_md_hi, r_md_lo[DATA_W-1]};
  assign w_div_ge   = w_div_sh >= {1'b0, r_md_b};
  assign w_div_diff = w_div_sh[DATA_W-1:0] - r_md_b;
  assign w_prod_mag = {r_md_hi, r_md_lo};
  assign w_prod     = r_md_neg_q ? -w_prod_mag : w_prod_mag;
  assign w_quot     = r_md_neg_q ? -r_md_lo : r_md_lo;
  assign w_rem      = r_md_neg_r ? -r_md_hi : r_md_hi;

  always_comb begin
    w_md_next = r_md_state;
    case (r_md_state)
      MD_IDLE: if (w_md_start) w_md_next = MD_RUN;
      MD_RUN:  if (r_md_cnt == '0) w_md_next = MD_DONE;
      MD_DONE: w_md_next = MD_IDLE;
      default: w_md_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_md_state <= MD_IDLE;
    else          r_md_state <= w_md_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_md_a      <= '0;
      r_md_b      <= '0;
      r_md_hi     <= '0;
      r_md_lo     <= '0;
      r_md_cnt    <= '0;
      r_md_is_div <= 1'b0;
      r_md_neg_q  <= 1'b0;
      r_md_neg_r  <= 1'b0;
    end else if (w_md_start) begin
      r_md_a      <= w_a;
      r_md_b      <= w_abs_b;
      r_md_hi     <= '0;
      r_md_lo     <= w_abs_a;
      r_md_cnt    <= SW'(DATA_W - 1);
      r_md_is_div <= (w_op == 4'd12);
      r_md_neg_q  <= w_a[DATA_W-1] ^ w_b[DATA_W-1];
      r_md_neg_r  <= w_a[DATA_W-1];
    end else if (r_md_state == MD_RUN) begin
      r_md_cnt <= r_md_cnt - SW'(1);
      if (r_md_is_div) begin
        r_md_hi <= w_div_ge ? w_div_diff : w_div_sh[DATA_W-1:0];
        r_md_lo <= {r_md_lo[DATA_W-2:0], w_div_ge};
      end else begin
        r_md_hi <= w_mul_sum[DATA_W:1];
        r_md_lo <= {w_mul_sum[0], r_md_lo[DATA_W-1:1]};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_zlo <= '0;
      r_zhi <= '0;
    end else if (r_md_state == MD_DONE) begin
      if (!r_md_is_div) begin
        {r_zhi, r_zlo} <= w_prod;
      end else if (r_md_b == '0) begin
        r_zlo <= '1;
        r_zhi <= r_md_a;
      end else begin
        r_zlo <= w_quot;
        r_zhi <= w_rem;
      end
    end else if (w_alu_z) begin
      r_zlo <= w_alu;
      r_zhi <= '0;
    end
  end

  // Memory unit: a read wins over a simultaneous write; MAR/MDR are frozen while a request is open.
  assign w_mem_start   = (r_mem_state == MEM_IDLE) && (i_mem_rd || i_mem_wr) && !o_busy;
  assign w_mem_rd_done = (r_mem_state == MEM_REQ) && i_mem_ack && !r_mem_we;

`ifdef DP_MEM_TIMEOUT_EN
  logic [3:0] r_to_cnt;
  logic       r_mem_err;

  assign w_timeout = (r_mem_state == MEM_REQ) && !i_mem_ack && (r_to_cnt == 4'd14);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt  <= 4'd0;
      r_mem_err <= 1'b0;
    end else begin
      r_to_cnt <= (r_mem_state == MEM_REQ) ? r_to_cnt + 4'd1 : 4'd0;
      if (w_timeout) r_mem_err <= 1'b1;
    end
  end

  assign o_mem_err = r_mem_err;
`else
  assign w_timeout = 1'b0;
  assign o_mem_err = 1'b0;
`endif

  always_comb begin
    w_mem_next = r_mem_state;
    case (r_mem_state)
      MEM_IDLE: if (w_mem_start) w_mem_next = MEM_REQ;
      MEM_REQ:  if (i_mem_ack || w_timeout) w_mem_next = MEM_IDLE;
      default:  w_mem_next = MEM_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_state <= MEM_IDLE;
      r_mem_we    <= 1'b0;
    end else begin
      r_mem_state <= w_mem_next;
      if (w_mem_start) r_mem_we <= i_mem_wr && !i_mem_rd;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_pc  <= '0;
      r_ir  <= '0;
      r_y   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_in  <= '0;
      r_out <= '0;
    end else begin
      if (i_reg_we) r_regs[i_dst_reg] <= w_bus;
      if (i_pc_in)  r_pc  <= w_bus;
      if (i_ir_in)  r_ir  <= w_bus;
      if (i_y_in)   r_y   <= w_bus;
      if (i_hi_in)  r_hi  <= w_bus;
      if (i_lo_in)  r_lo  <= w_bus;
      if (i_out_in) r_out <= w_bus;
      if (i_strobe) r_in  <= i_in_port;
      if (i_mar_in && r_mem_state == MEM_IDLE) r_mar <= w_bus;
      if (w_mem_rd_done)
        r_mdr <= i_mem_rdata;
      else if (i_mdr_in && r_mem_state == MEM_IDLE)
        r_mdr <= w_bus;
    end
  end

  assign o_busy      = (r_md_state != MD_IDLE) || (r_mem_state != MEM_IDLE);
  assign o_mem_req   = (r_mem_state == MEM_REQ);
  assign o_mem_we    = (r_mem_state == MEM_REQ) && r_mem_we;
  assign o_mem_addr  = r_mar;
  assign o_mem_wdata = r_mdr;
  assign o_out_port  = r_out;
  assign o_ir_value  = r_ir;

endmodule

// File: tb/tb_param_datapath.sv
// Scoreboard bench for param_datapath (DATA_W=32, NUM_REGS=16): expectations queued at stimulus, checked at output.
module tb_param_datapath;
  localparam int DW = 32;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic [2:0]    i_src_kind;
  logic [RW-1:0] i_src_reg, i_dst_reg;
  logic          i_ba_out, i_reg_we, i_pc_in, i_ir_in, i_y_in, i_mar_in, i_mdr_in;
  logic          i_hi_in, i_lo_in, i_out_in, i_inc_pc, i_c_out, i_z_in, i_mem_rd, i_mem_wr;
  logic [3:0]    i_alu_op;
  logic [DW-1:0] i_mem_rdata, i_in_port;
  logic          i_mem_ack, i_strobe;
  logic          o_mem_req, o_mem_we, o_busy, o_mem_err;
  logic [DW-1:0] o_mem_addr, o_mem_wdata, o_out_port, o_ir_value;

  int            n_checks = 0;
  int            n_pass   = 0;
  string         tag_q[$];
  logic [63:0]   exp_q[$];

  localparam logic [3:0]    OPS  [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                          4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd13};
  localparam logic [DW-1:0] EXPS [12] = '{32'h80000F13, 32'h80000F0B, 32'h00000004, 32'h80000F0F,
                                          32'h080000F0, 32'hF80000F0, 32'h0000F0F0, 32'hF80000F0,
                                          32'h0000F0F8, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'h00000000};

  param_datapath #(.DATA_W(DW), .NUM_REGS(16), .IMM_W(19)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_src_kind(i_src_kind), .i_src_reg(i_src_reg),
    .i_ba_out(i_ba_out), .i_reg_we(i_reg_we), .i_dst_reg(i_dst_reg), .i_pc_in(i_pc_in),
    .i_ir_in(i_ir_in), .i_y_in(i_y_in), .i_mar_in(i_mar_in), .i_mdr_in(i_mdr_in),
    .i_hi_in(i_hi_in), .i_lo_in(i_lo_in), .i_out_in(i_out_in), .i_inc_pc(i_inc_pc),
    .i_c_out(i_c_out), .i_alu_op(i_alu_op), .i_z_in(i_z_in), .i_mem_rd(i_mem_rd),
    .i_mem_wr(i_mem_wr), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .i_in_port(i_in_port), .i_strobe(i_strobe), .o_out_port(o_out_port),
    .o_ir_value(o_ir_value), .o_busy(o_busy), .o_mem_err(o_mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else begin
      n_pass++;
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 64'(exp_q.size()), 64'd1);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, obs, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    i_src_kind = 3'd0; i_src_reg = '0; i_dst_reg = '0; i_ba_out = 0; i_reg_we = 0;
    i_pc_in = 0; i_ir_in = 0; i_y_in = 0; i_mar_in = 0; i_mdr_in = 0; i_hi_in = 0;
    i_lo_in = 0; i_out_in = 0; i_inc_pc = 0; i_c_out = 0; i_alu_op = 4'd0; i_z_in = 0;
    i_mem_rd = 0; i_mem_wr = 0; i_mem_ack = 0; i_strobe = 0;
  endtask

  task automatic strobe_in(input logic [DW-1:0] v);
    i_in_port = v; i_strobe = 1; cyc(); i_strobe = 0;
  endtask

  task automatic load_reg(input int idx, input logic [DW-1:0] v);
    strobe_in(v);
    i_src_kind = 3'd7; i_reg_we = 1; i_dst_reg = RW'(idx); cyc(); clr();
  endtask

  task automatic set_y(input int idx);
    i_src_kind = 3'd0; i_src_reg = RW'(idx); i_y_in = 1; cyc(); clr();
  endtask

  task automatic read_src(input logic [2:0] kind, input int idx, output logic [DW-1:0] v);
    i_src_kind = kind; i_src_reg = RW'(idx); i_out_in = 1; cyc(); clr();
    v = o_out_port;
  endtask

  task automatic alu_rr(input logic [3:0] op, input int ya, input int rb);
    set_y(ya);
    i_src_kind = 3'd0; i_src_reg = RW'(rb); i_alu_op = op; i_z_in = 1; cyc(); clr();
  endtask

  task automatic md_run(input string tag, input logic [3:0] op, input int ya, input int rb,
                        input logic [DW-1:0] lo, input logic [DW-1:0] hi);
    int n;
    logic [DW-1:0] v;
    sb_push({tag, "_busy"}, 64'd33);
    sb_push({tag, "_zlo"}, 64'(lo));
    sb_push({tag, "_zhi"}, 64'(hi));
    alu_rr(op, ya, rb);
    n = 0;
    while (o_busy && n < 200) begin n++; cyc(); end
    sb_pop(64'(n));
    read_src(3'd2, 0, v); sb_pop(64'(v));
    read_src(3'd3, 0, v); sb_pop(64'(v));
  endtask

  initial begin
    logic [DW-1:0] v;
    int n;
    clr(); i_in_port = '0; i_mem_rdata = '0; i_rst_n = 0;
    repeat (2) cyc();
    sb_push("rst_busy", 0); sb_pop(64'(o_busy));
    sb_push("rst_ir", 0);   sb_pop(64'(o_ir_value));
    i_rst_n = 1; cyc();

    load_reg(1, 32'd7); load_reg(2, 32'hFFFFFFFD); load_reg(5, 32'h55); load_reg(0, 32'h1234);
    load_reg(3, 32'hFFFFFFFA); load_reg(4, 32'd7); load_reg(6, 32'h80000F0F); load_reg(7, 32'd4);
    load_reg(8, 32'hFFFFFFF9); load_reg(9, 32'd2); load_reg(10, 32'd0); load_reg(11, 32'd100);

    sb_push("r0_ba_out", 0);  i_ba_out = 1; read_src(3'd0, 0, v); sb_pop(64'(v));
    sb_push("r0", 32'h1234);  read_src(3'd0, 0, v); sb_pop(64'(v));

    sb_push("add_zlo", 32'd4); sb_push("add_zhi", 0);
    alu_rr(4'd0, 1, 2);
    read_src(3'd2, 0, v); sb_pop(64'(v));
    read_src(3'd3, 0, v); sb_pop(64'(v));

    // inc_pc must force ADD even with another op selected.
    strobe_in(32'h10); i_src_kind = 3'd7; i_pc_in = 1; cyc(); clr();
    sb_push("inc_pc", 32'h11);
    i_inc_pc = 1; i_src_kind = 3'd1; i_alu_op = 4'd1; i_z_in = 1; cyc(); clr();
    read_src(3'd2, 0, v); sb_pop(64'(v));

    for (int k = 0; k < 12; k++) begin
      sb_push($sformatf("alu_op%0d", OPS[k]), 64'(EXPS[k]));
      alu_rr(OPS[k], 6, 7);
      read_src(3'd2, 0, v); sb_pop(64'(v));
    end

    strobe_in(32'hFFF7FFFE); i_src_kind = 3'd7; i_ir_in = 1; cyc(); clr();
    sb_push("ir_value", 32'hFFF7FFFE); sb_pop(64'(o_ir_value));
    sb_push("c_out_imm", 32'd5);
    set_y(1); i_c_out = 1; i_alu_op = 4'd0; i_z_in = 1; cyc(); clr();
    read_src(3'd2, 0, v); sb_pop(64'(v));

    strobe_in(32'hA5A50001); i_src_kind = 3'd7; i_hi_in = 1; cyc(); clr();
    strobe_in(32'h5A5A0002); i_src_kind = 3'd7; i_lo_in = 1; cyc(); clr();
    sb_push("hi", 32'hA5A50001); read_src(3'd4, 0, v); sb_pop(64'(v));
    sb_push("lo", 32'h5A5A0002); read_src(3'd5, 0, v); sb_pop(64'(v));

    md_run("mul_neg", 4'd11, 3, 4, 32'hFFFFFFD6, 32'hFFFFFFFF);
    md_run("mul_pos", 4'd11, 11, 4, 32'h000002BC, 32'h00000000);
    md_run("div_neg", 4'd12, 8, 9, 32'hFFFFFFFD, 32'hFFFFFFFF);
    md_run("div_negdiv", 4'd12, 11, 8, 32'hFFFFFFF2, 32'h00000002);
    md_run("div_zero", 4'd12, 8, 10, 32'hFFFFFFFF, 32'hFFFFFFF9);

    // Memory read with 3-cycle ack; MAR write attempt during REQ must be ignored.
    strobe_in(32'h40); i_src_kind = 3'd7; i_mar_in = 1; cyc(); clr();
    sb_push("rd_req", 1); sb_push("rd_we", 0); sb_push("rd_req_cycles", 3);
    sb_push("rd_addr", 32'h40); sb_push("rd_mdr", 32'hDEADBEEF);
    i_mem_rd = 1; cyc(); clr();
    sb_pop(64'(o_mem_req)); sb_pop(64'(o_mem_we));
    n = 0;
    while (o_mem_req && n < 50) begin
      n++;
      if (n == 1) begin i_src_kind = 3'd1; i_mar_in = 1; end
      if (n == 3) begin i_mem_ack = 1; i_mem_rdata = 32'hDEADBEEF; end
      cyc(); clr();
    end
    sb_pop(64'(n)); sb_pop(64'(o_mem_addr)); sb_pop(64'(o_mem_wdata));

    sb_push("idle_ack_ignored", 32'hDEADBEEF);
    i_mem_ack = 1; i_mem_rdata = 32'h12345678; cyc(); clr();
    sb_pop(64'(o_mem_wdata));

    // Read+write together performs the read; single-cycle ADD proceeds while memory is busy.
    sb_push("rdwr_req", 1); sb_push("rdwr_we", 0); sb_push("add_during_mem", 32'd14);
    sb_push("rdwr_mdr", 32'hCAFEF00D); sb_push("rdwr_busy_after", 0);
    i_mem_rd = 1; i_mem_wr = 1; cyc(); clr();
    sb_pop(64'(o_mem_req)); sb_pop(64'(o_mem_we));
    alu_rr(4'd0, 1, 1);
    i_mem_ack = 1; i_mem_rdata = 32'hCAFEF00D; cyc(); clr();
    read_src(3'd2, 0, v); sb_pop(64'(v));
    sb_pop(64'(o_mem_wdata)); sb_pop(64'(o_busy));

    sb_push("wr_we", 1); sb_push("wr_wdata", 32'hCAFEF00D); sb_push("wr_mdr_kept", 32'hCAFEF00D);
    i_mem_wr = 1; cyc(); clr();
    sb_pop(64'(o_mem_we)); sb_pop(64'(o_mem_wdata));
    i_mem_ack = 1; i_mem_rdata = 32'h0; cyc(); clr();
    sb_pop(64'(o_mem_wdata));

    // Withheld ack.
`ifdef DP_MEM_TIMEOUT_EN
    sb_push("to_req_cycles", 15); sb_push("to_mem_err", 1); sb_push("to_mdr", 32'hCAFEF00D);
`else
    sb_push("to_req_cycles", 100); sb_push("to_mem_err", 0); sb_push("to_mdr", 32'hCAFEF00D);
`endif
    i_mem_rdata = 32'h0BADF00D; i_mem_rd = 1; cyc(); clr();
    n = 0;
    while (o_mem_req && n < 100) begin n++; cyc(); end
    sb_pop(64'(n)); sb_pop(64'(o_mem_err)); sb_pop(64'(o_mem_wdata));
    if (o_mem_req) begin i_mem_ack = 1; cyc(); clr(); end

    // Asynchronous reset in the middle of a multiply.
    sb_push("mid_busy", 1); sb_push("rst_busy_async", 0); sb_push("rst_req_async", 0);
    sb_push("rst_out_async", 0); sb_push("rst_r5", 0);
    alu_rr(4'd11, 3, 4);
    repeat (5) cyc();
    sb_pop(64'(o_busy));
    i_rst_n = 0; #1;
    sb_pop(64'(o_busy)); sb_pop(64'(o_mem_req)); sb_pop(64'(o_out_port));
    cyc(); i_rst_n = 1; cyc();
    read_src(3'd0, 5, v); sb_pop(64'(v));

    check("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/param_datapath.md
Name: param_datapath

Overview:
Second-generation bus-based datapath for the Mini SRC processor. Builds on the fixed 32-bit, 16-register datapath and adds the following:
- parametrised data width and register count
- encoded bus-source select, replacing one-hot out strobes
- an iterative multi-cycle MUL/DIV unit
- a request/acknowledge memory interface, replacing the combinational RAM
It sits under the control unit, which drives the control inputs each cycle and stalls while busy is high.

Parameters:
DATA_W, 32, datapath width; even, 8..64
NUM_REGS, 16, general registers; power of 2, 2..32; RW = log2(NUM_REGS)
IMM_W, 19, IR immediate width; sign-extended to DATA_W when c_out=1

Ports:
Clock  in  1  rising-edge clock
Clear  in  1  asynchronous active-low reset
src_kind  in  3  bus source: 0 REG, 1 PC, 2 ZLO, 3 ZHI, 4 HI, 5 LO, 6 MDR, 7 INPORT
src_reg  in  RW  register index when src_kind=0
ba_out  in  1  with src_kind=0 and src_reg=0, bus=0
reg_we, dst_reg  in  1, RW  general-register write from bus
pc_in, ir_in, y_in, mar_in, mdr_in, hi_in, lo_in, out_in  in  1 each  load register from bus
inc_pc  in  1  ALU A=1, op forced ADD
c_out  in  1  ALU B = sign-extended IR[IMM_W-1:0], else B = bus
alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG, 10 NOT, 11 MUL, 12 DIV; others give 0
z_in  in  1  capture ALU result into Z, or start MUL/DIV
mem_rd, mem_wr  in  1  start a memory read or write (pulse)
mem_req, mem_we  out  1  memory request, write qualifier
mem_addr, mem_wdata  out  DATA_W  MAR, MDR
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_ack  in  1  completes the current request
in_port  in  DATA_W  external input
strobe  in  1  latch in_port into input register
out_port  out  DATA_W  output-port register
ir_value  out  DATA_W  IR contents, for the control unit
busy  out  1  MUL/DIV or memory operation in progress
mem_err  out  1  sticky timeout flag (see Optional Feature)

Behaviour:
- Reset (Clear=0, asynchronous): all registers, Z, HI, LO, MAR, MDR, IR, PC, input and output ports cleared to 0. Both FSMs go IDLE. busy, mem_req, mem_we and mem_err are 0.
- Bus is a combinational mux on src_kind/src_reg. An out-of-range src_reg drives 0.
- All register loads occur on the rising Clock edge. Multiple destinations may load from the bus in the same cycle.
- ALU operand A is Y, or 1 when inc_pc=1.
- Shifts and rotates use B[log2(DATA_W)-1:0]. SHRA is arithmetic. NEG is two's complement of B; NOT is the complement of B.
- Single-cycle ops: when z_in=1, Zlo <= result and Zhi <= 0 (ADD/SUB carry/borrow is not kept). Latency is 1 cycle.
- MUL/DIV FSM, states IDLE, RUN, DONE:
  - z_in with op 11/12 in IDLE latches A and B and enters RUN for DATA_W cycles (radix-2), then DONE for 1 cycle, which writes Z. busy is high from the cycle after start through DONE.
  - MUL: signed; {Zhi,Zlo} = full 2*DATA_W product.
  - DIV: signed, truncates toward zero. Zlo = quotient; Zhi = remainder, which takes the sign of the dividend.
  - Divide by zero: Zlo = all ones, Zhi = dividend.
  - z_in while busy is ignored.
- Memory FSM, states IDLE, REQ:
  - mem_rd or mem_wr in IDLE enters REQ. mem_req=1 and mem_addr=MAR are held stable until mem_ack. mem_we=1 for a write, and mem_wdata is held constant.
  - An ack in REQ returns the FSM to IDLE. For a read, MDR <= mem_rdata on that edge.
  - mem_ack while IDLE is ignored.
  - mem_rd and mem_wr together: the read is performed and the write dropped.
  - mem_rd/mem_wr while busy are ignored.
  - mdr_in and mar_in are ignored while the memory FSM is in REQ.
- busy = MUL/DIV active OR memory FSM not IDLE. The two units may run concurrently.
- Input register loads in_port on each cycle strobe=1.
- out_port is the output register; it is loaded when out_in=1.

Optional Feature:
Macro DP_MEM_TIMEOUT_EN.
- Defined: a 4-bit counter runs in REQ. If mem_ack is absent for 15 cycles, the FSM aborts to IDLE, MDR is unchanged, and mem_err is set (sticky until Clear).
- Undefined: no counter, REQ waits indefinitely, and mem_err is tied to 0.

Test Plan:
- Reset: with Clear=0 mid-MUL (busy=1) -> busy=0, mem_req=0, out_port=0. After release, reading R5 on the bus gives 0.
- ADD: R1=7, R2=-3; Y<=R1, src R2, ADD, z_in -> Zlo=4, Zhi=0 the next cycle. Same with inc_pc and PC=0x10 -> Zlo=0x11.
- MUL and divide-by-zero: MUL -6 * 7 -> busy for 33 cycles (DATA_W=32), {Zhi,Zlo}=-42 sign-extended. DIV -7/2 -> Zlo=-3, Zhi=-1. DIV by 0 -> Zlo=0xFFFFFFFF, Zhi=dividend.
- Memory read: MAR=0x40, mem_rd, ack after 3 cycles with rdata 0xDEADBEEF -> mem_req high for 3 cycles, MDR=0xDEADBEEF. A mar_in pulse during REQ -> mem_addr stays 0x40.
- Memory write plus ALU op: simultaneous mem_rd+mem_wr -> mem_we=0. A z_in during mem busy with single-cycle ADD -> Z updates.
- Timeout (macro on): withhold mem_ack -> mem_req drops after 15 cycles, mem_err=1, MDR unchanged. With the macro off, mem_req stays high for 100 cycles.
